// File: rtl/bus_arbiter.sv
// Two-port arbiter multiplexing the fetcher and data port onto one external 16-bit bus.
// Ownership is registered, ties alternate, and an ack watchdog strobes err to the owner.
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [63:0] f_adr_i,
  input  logic [1:0]  f_size_i,
  output logic [15:0] f_dat_o,
  output logic        f_ack_o,
  output logic        f_err_o,
  input  logic [63:0] d_adr_i,
  input  logic [1:0]  d_size_i,
  input  logic        d_we_i,
  input  logic [15:0] d_dat_i,
  output logic [15:0] d_dat_o,
  output logic        d_ack_o,
  output logic        d_err_o,
  output logic [63:0] adr_o,
  output logic [1:0]  size_o,
  output logic        we_o,
  output logic [15:0] dat_o,
  output logic        vpa_o,
  input  logic [15:0] dat_i,
  input  logic        ack_i
);

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnF    = 2'd1,
    OwnD    = 2'd2
  } owner_e;

  localparam logic [15:0] WaitLimit = 16'(TIMEOUT_CYCLES - 1);

  owner_e      owner_q, owner_d;
  logic        last_is_d_q, last_is_d_d;
  logic [15:0] wait_q, wait_d;
  logic        f_req, d_req, own_req, timeout;

  assign f_dat_o = dat_i;
  assign d_dat_o = dat_i;

  always_comb begin
    f_req   = |f_size_i;
    d_req   = |d_size_i;
    own_req = 1'b0;
    unique case (owner_q)
      OwnF:    own_req = f_req;
      OwnD:    own_req = d_req;
      default: own_req = 1'b0;
    endcase
    timeout = (owner_q != OwnNone) && (wait_q == WaitLimit) && !ack_i;

    // Owner keeps the bus while its size stays nonzero, so multi-halfword fetches are atomic.
    owner_d = OwnNone;
    if (timeout) begin
      owner_d = OwnNone;
    end else if ((owner_q != OwnNone) && own_req) begin
      owner_d = owner_q;
    end else if (f_req && d_req) begin
      owner_d = last_is_d_q ? OwnF : OwnD;
    end else if (f_req) begin
      owner_d = OwnF;
    end else if (d_req) begin
      owner_d = OwnD;
    end

    last_is_d_d = last_is_d_q;
    if (owner_d != OwnNone) begin
      last_is_d_d = (owner_d == OwnD);
    end

    wait_d = wait_q;
    if (ack_i || (owner_d != owner_q)) begin
      wait_d = 16'd0;
    end else if (owner_q != OwnNone) begin
      wait_d = wait_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      owner_q     <= OwnNone;
      last_is_d_q <= 1'b1;
      wait_q      <= 16'd0;
    end else begin
      owner_q     <= owner_d;
      last_is_d_q <= last_is_d_d;
      wait_q      <= wait_d;
    end
  end

  always_comb begin
    adr_o   = 64'd0;
    size_o  = 2'd0;
    we_o    = 1'b0;
    dat_o   = 16'd0;
    vpa_o   = 1'b0;
    f_ack_o = 1'b0;
    d_ack_o = 1'b0;
    f_err_o = 1'b0;
    d_err_o = 1'b0;
    if (!reset_i) begin
      unique case (owner_q)
        OwnF: begin
          adr_o   = f_adr_i;
          size_o  = f_size_i;
          vpa_o   = 1'b1;
          f_ack_o = ack_i;
          f_err_o = timeout;
        end
        OwnD: begin
          adr_o   = d_adr_i;
          size_o  = d_size_i;
          we_o    = d_we_i;
          dat_o   = d_we_i ? d_dat_i : 16'd0;
          d_ack_o = ack_i;
          d_err_o = timeout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic against a cycle-level
// ownership model derived from the arbitration rules.
module tb_bus_arbiter;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] f_adr, d_adr;
  logic [1:0]  f_size, d_size;
  logic        d_we, ack;
  logic [15:0] d_dat, dat_in;

  logic [15:0] f_dat_o, d_dat_o, dat_o;
  logic        f_ack_o, f_err_o, d_ack_o, d_err_o, we_o, vpa_o;
  logic [63:0] adr_o;
  logic [1:0]  size_o;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: owner 0 = none, 1 = fetcher, 2 = data port; last is 1 or 2.
  int m_owner, m_last, m_wait;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i    (clk),
    .reset_i  (rst),
    .f_adr_i  (f_adr),
    .f_size_i (f_size),
    .f_dat_o  (f_dat_o),
    .f_ack_o  (f_ack_o),
    .f_err_o  (f_err_o),
    .d_adr_i  (d_adr),
    .d_size_i (d_size),
    .d_we_i   (d_we),
    .d_dat_i  (d_dat),
    .d_dat_o  (d_dat_o),
    .d_ack_o  (d_ack_o),
    .d_err_o  (d_err_o),
    .adr_o    (adr_o),
    .size_o   (size_o),
    .we_o     (we_o),
    .dat_o    (dat_o),
    .vpa_o    (vpa_o),
    .dat_i    (dat_in),
    .ack_i    (ack)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Let combinational outputs settle, then compare everything against the model.
  task automatic settle();
    logic [63:0] e_adr;
    logic [1:0]  e_size;
    logic        e_we, e_vpa, e_fack, e_dack, e_ferr, e_derr, to;
    logic [15:0] e_dat;
    #1;
    e_adr = '0; e_size = '0; e_we = 0; e_vpa = 0; e_dat = '0;
    e_fack = 0; e_dack = 0; e_ferr = 0; e_derr = 0;
    to = (m_owner != 0) && (m_wait == T - 1) && !ack;
    if (!rst && m_owner == 1) begin
      e_adr = f_adr; e_size = f_size; e_vpa = 1; e_fack = ack; e_ferr = to;
    end else if (!rst && m_owner == 2) begin
      e_adr = d_adr; e_size = d_size; e_we = d_we; e_dat = d_we ? d_dat : 16'd0;
      e_dack = ack; e_derr = to;
    end
    check_val("m_adr", adr_o, e_adr);
    check_val("m_ctl", {56'd0, size_o, we_o, vpa_o, f_ack_o, d_ack_o, f_err_o, d_err_o},
              {56'd0, e_size, e_we, e_vpa, e_fack, e_dack, e_ferr, e_derr});
    check_val("m_dat", {16'd0, dat_o, f_dat_o, d_dat_o}, {16'd0, e_dat, dat_in, dat_in});
  endtask

  // Advance one clock and apply the ownership rules to the model.
  task automatic tick();
    int  nxt, cur_size;
    bit  to;
    @(posedge clk);
    if (rst) begin
      m_owner = 0; m_last = 2; m_wait = 0;
    end else begin
      to = (m_owner != 0) && (m_wait == T - 1) && !ack;
      cur_size = (m_owner == 1) ? int'(f_size) : (m_owner == 2) ? int'(d_size) : 0;
      if (to) nxt = 0;
      else if (m_owner != 0 && cur_size != 0) nxt = m_owner;
      else if (f_size != 0 && d_size != 0) nxt = 3 - m_last;
      else if (f_size != 0) nxt = 1;
      else if (d_size != 0) nxt = 2;
      else nxt = 0;
      if (ack || nxt != m_owner) m_wait = 0;
      else if (m_owner != 0) m_wait++;
      if (nxt != 0) m_last = nxt;
      m_owner = nxt;
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  initial begin
    m_owner = 0; m_last = 2; m_wait = 0;
    rst = 1; f_adr = '0; d_adr = '0; f_size = 0; d_size = 0;
    d_we = 0; d_dat = '0; ack = 0; dat_in = 16'hA5A5;
    @(negedge clk);

    // Reset with idle bus, then release with no requests.
    for (int i = 0; i < 2; i++) begin
      settle(); check_val("rst_size", size_o, 0); check_val("rst_ack", {f_ack_o, d_ack_o}, 0);
      tick();
    end
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      settle(); check_val("idle_size", size_o, 0); tick();
    end

    // Fetch only with continuous ack.
    f_size = 2; f_adr = 64'hFFFF_FFFF_FFFF_FF00; ack = 1;
    settle(); check_val("f_lat_size", size_o, 0); tick();
    settle();
    check_val("f_adr", adr_o, 64'hFFFF_FFFF_FFFF_FF00);
    check_val("f_size", size_o, 2);
    check_val("f_vpa", vpa_o, 1);
    check_val("f_ack", f_ack_o, 1);
    check_val("f_dat", f_dat_o, 16'hA5A5);
    tick();
    f_adr = 64'hFFFF_FFFF_FFFF_FF02;
    settle(); check_val("f_hold_adr", adr_o, 64'hFFFF_FFFF_FFFF_FF02);
    check_val("f_hold_vpa", vpa_o, 1); tick();
    f_size = 0;
    settle(); check_val("f_rel_size", size_o, 0); tick();

    // Data write while the fetcher waits.
    d_size = 2; d_we = 1; d_dat = 16'h1234; d_adr = 64'h100;
    cyc();
    f_size = 2;
    for (int i = 0; i < 2; i++) begin
      settle();
      check_val("d_dat", dat_o, 16'h1234);
      check_val("d_we", we_o, 1);
      check_val("d_ack", d_ack_o, 1);
      check_val("d_blk_fack", f_ack_o, 0);
      tick();
    end
    d_size = 0;
    settle(); check_val("d_rel_size", size_o, 0); tick();
    settle(); check_val("handoff_vpa", vpa_o, 1); check_val("handoff_size", size_o, 2); tick();
    f_size = 0; d_we = 0;
    cyc();

    // Tie fairness from reset (last = data port).
    rst = 1; cyc(); rst = 0;
    f_size = 2; d_size = 1;
    cyc();
    settle(); check_val("tie1_vpa", vpa_o, 1); tick();
    f_size = 0;
    settle(); check_val("tie_rel_size", size_o, 0); tick();
    settle(); check_val("tie2_size", size_o, 1); check_val("tie2_vpa", vpa_o, 0); tick();
    d_size = 0;
    cyc();
    f_size = 2; d_size = 1;
    cyc();
    settle(); check_val("tie3_vpa", vpa_o, 1); tick();
    f_size = 0; d_size = 0;
    cyc(); cyc();

    // Watchdog: timeout on 4th granted cycle, then ack on the threshold cycle wins.
    f_size = 2; ack = 0;
    cyc();
    for (int i = 1; i <= T; i++) begin
      settle(); check_val("to_err", f_err_o, (i == T)); tick();
    end
    settle(); check_val("to_idle", size_o, 0); check_val("to_err_once", f_err_o, 0); tick();
    for (int i = 1; i <= T; i++) begin
      ack = (i == T);
      settle(); check_val("ackwin_err", f_err_o, 0); check_val("ackwin_ack", f_ack_o, (i == T));
      tick();
    end
    f_size = 0;
    cyc();

    // Reset in the middle of a data transfer.
    d_size = 2; d_we = 1; ack = 0;
    cyc();
    settle(); check_val("mid_size", size_o, 2); tick();
    rst = 1; ack = 1;
    settle(); check_val("mid_rst_size", size_o, 0); check_val("mid_rst_ack", d_ack_o, 0);
    check_val("mid_rst_we", we_o, 0); tick();
    rst = 0; d_size = 0; f_size = 2;
    settle(); check_val("post_rst_size", size_o, 0); tick();
    settle(); check_val("post_rst_vpa", vpa_o, 1); tick();
    f_size = 0;
    cyc();

    // Random traffic, including illegal size 11 and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) f_size = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) d_size = 2'($urandom_range(0, 3));
      f_adr = {$urandom, $urandom};
      d_adr = {$urandom, $urandom};
      d_we = 1'($urandom);
      d_dat = 16'($urandom);
      dat_in = 16'($urandom);
      ack = ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Upstream neighbour of the instruction fetcher. Multiplexes the fetcher's 16-bit opcode port and the execute unit's 16-bit load/store port onto the single external 16-bit bus.
- Registered ownership with fair tie-breaking.
- An ack-timeout watchdog returns an error strobe to whichever side owns the bus.
- Drives the fetcher's dat_i/ack_i directly.

Parameters:
TIMEOUT_CYCLES, 255, cycles a granted transfer may wait for ack_i before err is raised (legal 2..65535).

Ports:
clk_i  in  1  clock; all state changes on rising edge
reset_i  in  1  synchronous, active-high reset
f_adr_i  in  64  fetcher address
f_size_i  in  2  fetcher size; nonzero = request (00 none, 01 byte, 10 halfword)
f_dat_o  out  16  read data to fetcher (= dat_i)
f_ack_o  out  1  fetcher acknowledge
f_err_o  out  1  fetcher timeout strobe (for future trap logic)
d_adr_i  in  64  data-port address
d_size_i  in  2  data-port size; nonzero = request
d_we_i  in  1  data-port write enable
d_dat_i  in  16  data-port write data
d_dat_o  out  16  read data to data port (= dat_i)
d_ack_o  out  1  data-port acknowledge
d_err_o  out  1  data-port timeout strobe
adr_o  out  64  external address
size_o  out  2  external size; 00 = bus idle
we_o  out  1  external write enable
dat_o  out  16  external write data
vpa_o  out  1  high while the fetcher owns the bus (opcode cycle)
dat_i  in  16  external read data
ack_i  in  1  external acknowledge

Behaviour:
- State: owner ∈ {NONE, F, D} (2-bit reg); last ∈ {F, D}; wait counter, 16 bits.
- Reset: owner=NONE, last=D, counter=0.
- While reset_i=1 all outputs are forced idle combinationally: size_o=0, we_o=0, adr_o=0, dat_o=0, vpa_o=0, acks=0, errs=0.
- Bus mux from the registered owner:
  - NONE: size_o=0, adr_o=0, we_o=0, dat_o=0.
  - F: adr_o=f_adr_i, size_o=f_size_i, we_o=0, dat_o=0, vpa_o=1.
  - D: adr_o=d_adr_i, size_o=d_size_i, we_o=d_we_i, dat_o=d_we_i ? d_dat_i : 0.
- Acks: f_ack_o = ack_i & owner==F; d_ack_o = ack_i & owner==D. Never both high.
- f_dat_o and d_dat_o are always dat_i.
- Grant latency: a request first seen in cycle N is granted (owner updated) at edge N+1, so the bus is driven from cycle N+1.
- Requester responsibility: hold the request until ack. The fetcher does this, since it waits for ack in its post-request state.
- Next-owner rule, in priority order:
  1. reset → NONE.
  2. timeout this cycle → NONE.
  3. owner≠NONE and owner's size≠0 → keep owner. Ownership is held across back-to-back halfword cycles, so a 32-bit opcode fetch is atomic.
  4. Both request → the side ≠ last.
  5. Only one requests → that side.
  6. Otherwise → NONE.
- last is updated to the new owner whenever owner changes to F or D.
- Release: when the owner drops size to 00, the bus is idle that cycle. Handoff to a waiting requester takes effect at the next edge, with no extra dead cycle.
- Watchdog:
  - counter clears on reset, on ack_i=1, and on any owner change.
  - Otherwise it increments while owner≠NONE and ack_i=0.
  - When counter==TIMEOUT_CYCLES-1 and ack_i=0, the owner's err strobe goes high for exactly that cycle and owner→NONE at the next edge.
- Simultaneous ack_i and timeout threshold: ack wins, no err.
- On err, the requester must drop its request. If it keeps requesting, it re-arbitrates normally.
- size 11 is illegal upstream and is passed through unchecked.
- Reset mid-transfer: owner→NONE at that edge. Any late ack_i is ignored because owner is NONE.

Test Plan:
- Reset, idle bus: reset_i=1 for 2 cycles → size_o=0, f_ack_o=0, d_ack_o=0. Release with no requests → size_o stays 0.
- Fetch only, ack_i=1 continuous:
  - f_size_i=2, f_adr_i=FFFF_FFFF_FFFF_FF00 from cycle 0 → cycle 1 adr_o=…FF00, size_o=2, vpa_o=1, f_ack_o=1, f_dat_o=dat_i.
  - Then f_adr_i=…FF02 with request held → owner stays F, no idle cycle.
- Data write contention:
  - D owns, d_we_i=1, d_dat_i=1234 → dat_o=1234, we_o=1.
  - Fetch requests meanwhile → f_ack_o=0 until D drops size. The next edge grants F, and vpa_o=1.
- Tie fairness: last=D, both request from idle → F granted first. After F releases with D still requesting → D granted. A new simultaneous tie then → F.
- Timeout: TIMEOUT_CYCLES=4, F owns, ack_i=0 → f_err_o=1 on the 4th granted cycle only, then owner=NONE (size_o=0). ack_i=1 on that 4th cycle instead → f_ack_o=1, f_err_o=0.
- Reset mid-transfer: D owns with ack_i=0, reset_i=1 for one cycle → outputs idle in that cycle. After reset with only the fetcher requesting → F granted one cycle later.
